// File: rtl/regfile_pkg.sv
// Shared defaults for the bypassing register file.
// The zero register index is kept here so every file agrees on it.
package regfile_pkg;

    localparam int          DEFAULT_DATA_W = 32;
    localparam int          DEFAULT_ADDR_W = 5;
    localparam int unsigned ZERO_ADDR      = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: same-cycle write-back bypass, zero-register forcing and the
// per-port share of the hazard stall.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              pending_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] control_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] data_o,
    output logic              stall_o
);

    logic zero_hit_s;
    logic bypass_hit_s;

    assign zero_hit_s   = (ZERO_REG != 0) && (addr_i == ADDR_W'(ZERO_ADDR));
    assign bypass_hit_s = wr_i && (control_i == addr_i);

    // Data select: reset and zero register dominate, then bypass, then storage.
    always_comb begin
        data_o = {DATA_W{1'b0}};
        if (rst_i || zero_hit_s) begin
            data_o = {DATA_W{1'b0}};
        end else if (bypass_hit_s) begin
            data_o = wdata_i;
        end else begin
            data_o = stored_i;
        end
    end

    // A pending source is only a hazard if this cycle's write-back doesn't cover it.
    always_comb begin
        stall_o = 1'b0;
        if (rst_i || zero_hit_s) begin
            stall_o = 1'b0;
        end else begin
            stall_o = pending_i && !bypass_hit_s;
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with write-back bypass and a per-register
// outstanding-write scoreboard that raises stall on unresolved source hazards.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     rs,
    input  logic [ADDR_W-1:0]     rt,
    output logic [DATA_W-1:0]     outputA,
    output logic [DATA_W-1:0]     outputB,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     control,
    input  logic [DATA_W-1:0]     write_back_reg,
    input  logic                  issue_valid,
    input  logic [ADDR_W-1:0]     issue_dest,
    output logic                  stall,
    output logic [2**ADDR_W-1:0]  pending
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  pending_d;
    logic              wr_en_s;
    logic              stall_a_s;
    logic              stall_b_s;

    assign wr_en_s = wr && !((ZERO_REG != 0) && (control == ADDR_W'(ZERO_ADDR)));

    // Scoreboard next state: clear on write-back first so a same-edge issue wins.
    always_comb begin
        pending_d = pending_q;
        if (wr) begin
            pending_d[control] = 1'b0;
        end else begin
            pending_d[control] = pending_q[control];
        end
        if (issue_valid) begin
            pending_d[issue_dest] = 1'b1;
        end else begin
            pending_d[issue_dest] = pending_d[issue_dest];
        end
        if (ZERO_REG != 0) begin
            pending_d[ADDR_W'(ZERO_ADDR)] = 1'b0;
        end else begin
            pending_d[ADDR_W'(ZERO_ADDR)] = pending_d[ADDR_W'(ZERO_ADDR)];
        end
    end

    // Storage and scoreboard state; reset wipes both without waiting for a clock.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            pending_q <= {DEPTH{1'b0}};
        end else begin
            pending_q <= pending_d;
            if (wr_en_s) begin
                regs_q[control] <= write_back_reg;
            end
        end
    end

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_port_a (
        .rst_i     (rst),
        .addr_i    (rs),
        .stored_i  (regs_q[rs]),
        .pending_i (pending_q[rs]),
        .wr_i      (wr),
        .control_i (control),
        .wdata_i   (write_back_reg),
        .data_o    (outputA),
        .stall_o   (stall_a_s)
    );

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_port_b (
        .rst_i     (rst),
        .addr_i    (rt),
        .stored_i  (regs_q[rt]),
        .pending_i (pending_q[rt]),
        .wr_i      (wr),
        .control_i (control),
        .wdata_i   (write_back_reg),
        .data_o    (outputB),
        .stall_o   (stall_b_s)
    );

    assign stall   = stall_a_s | stall_b_s;
    assign pending = pending_q;

endmodule
